// File: rtl/ram_pkg.sv
// Shared widths, return-record shape and elaboration helpers for the ram_pipe memory model.
package ram_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  // Return record at the default widths; ram_pipe builds the same shape at its own widths.
  typedef struct packed {
    logic                  ack;
    logic [ADDR_W_DEF-1:0] address;
    logic [DATA_W_DEF-1:0] data;
    logic                  err;
  } ram_ret_t;

  function automatic bit lat_ok(input int lat);
    return lat >= 1;
  endfunction

endpackage

// File: rtl/ram_ret_pipe.sv
// LATENCY-deep valid/payload delay line; payload is zeroed when not valid so idle outputs read 0.
module ram_ret_pipe #(
  parameter int LATENCY = 1,
  parameter int W       = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         vld_i,
  input  logic [W-1:0] pay_i,
  output logic         vld_o,
  output logic [W-1:0] pay_o
);

  logic [LATENCY:1]         vld_pipe_q;
  logic [LATENCY:1][W-1:0]  pay_pipe_q;
  logic [W-1:0]             pay_d;

  assign pay_d = vld_i ? pay_i : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      pay_pipe_q <= '0;
    end else begin
      vld_pipe_q[1] <= vld_i;
      pay_pipe_q[1] <= pay_d;
      for (int s = 2; s <= LATENCY; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        pay_pipe_q[s] <= pay_pipe_q[s-1];
      end
    end
  end

  assign vld_o = vld_pipe_q[LATENCY];
  assign pay_o = pay_pipe_q[LATENCY];

endmodule

// File: rtl/ram_pipe.sv
// Pipelined write/read memory model with range-checked requests and address-echoing returns.
// Define RAM_PIPE_FORWARD_EN for write-first forwarding on same-edge read/write collisions.
module ram_pipe
  import ram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH      = 65536,
  parameter int WR_LATENCY = 1,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ret_ack,
  output logic [ADDR_W-1:0] wr_ret_address,
  output logic              wr_ret_err,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_address,
  output logic              rd_ret_ack,
  output logic [ADDR_W-1:0] rd_ret_address,
  output logic [DATA_W-1:0] rd_ret_data,
  output logic              rd_ret_err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              err;
  } wr_pay_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              err;
  } rd_pay_t;

  if (!lat_ok(WR_LATENCY) || !lat_ok(RD_LATENCY)) begin : g_bad_lat
    $error("ram_pipe: WR_LATENCY and RD_LATENCY must be >= 1");
  end
  if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
    $error("ram_pipe: DEPTH must lie in 1..2**ADDR_W");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic             wr_acc, rd_acc, wr_ok, rd_ok;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [DATA_W-1:0] rd_raw, rd_data_d;
  wr_pay_t          wr_pay_d, wr_pay_q;
  rd_pay_t          rd_pay_d, rd_pay_q;

  // Requests presented while reset is high are dropped outright.
  assign wr_acc = wr_en & ~reset;
  assign rd_acc = rd_en & ~reset;
  assign wr_ok  = {1'b0, wr_address} < DEPTH_L;
  assign rd_ok  = {1'b0, rd_address} < DEPTH_L;
  assign wr_idx = wr_address[IDX_W-1:0];
  assign rd_idx = rd_address[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (wr_acc && wr_ok) mem_q[wr_idx] <= wr_data;
  end

  // Combinational read sees the array before this edge's write lands.
  assign rd_raw = rd_ok ? mem_q[rd_idx] : '0;

`ifdef RAM_PIPE_FORWARD_EN
  logic fwd;
  assign fwd       = wr_acc && wr_ok && rd_ok && (wr_address == rd_address);
  assign rd_data_d = fwd ? wr_data : rd_raw;
`else
  assign rd_data_d = rd_raw;
`endif

  always_comb begin
    wr_pay_d         = '0;
    wr_pay_d.address = wr_address;
    wr_pay_d.err     = ~wr_ok;
    rd_pay_d         = '0;
    rd_pay_d.address = rd_address;
    rd_pay_d.data    = rd_data_d;
    rd_pay_d.err     = ~rd_ok;
  end

  ram_ret_pipe #(.LATENCY(WR_LATENCY), .W($bits(wr_pay_t))) u_wr_ret (
    .clk   (clk),
    .reset (reset),
    .vld_i (wr_acc),
    .pay_i (wr_pay_d),
    .vld_o (wr_ret_ack),
    .pay_o (wr_pay_q)
  );

  ram_ret_pipe #(.LATENCY(RD_LATENCY), .W($bits(rd_pay_t))) u_rd_ret (
    .clk   (clk),
    .reset (reset),
    .vld_i (rd_acc),
    .pay_i (rd_pay_d),
    .vld_o (rd_ret_ack),
    .pay_o (rd_pay_q)
  );

  assign wr_ret_address = wr_pay_q.address;
  assign wr_ret_err     = wr_pay_q.err;
  assign rd_ret_address = rd_pay_q.address;
  assign rd_ret_data    = rd_pay_q.data;
  assign rd_ret_err     = rd_pay_q.err;

endmodule

// File: tb/tb_ram_pipe.sv
// Scoreboard bench for ram_pipe: two instances (latencies 2/3 and 1/1, DEPTH 256) share one stimulus stream.
module tb_ram_pipe;
  import ram_pkg::*;

  localparam int DEPTH = 256;
  localparam int WL[2] = '{2, 1};
  localparam int RL[2] = '{3, 1};

  typedef struct {
    int       due;
    ram_ret_t r;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [15:0] wr_address = '0, wr_data = '0, rd_address = '0;

  logic        a_wack, a_werr, a_rack, a_rerr, b_wack, b_werr, b_rack, b_rerr;
  logic [15:0] a_waddr, a_raddr, a_rdata, b_waddr, b_raddr, b_rdata;

  logic        o_ack  [4];
  logic [15:0] o_addr [4];
  logic [15:0] o_data [4];
  logic        o_err  [4];

  exp_t        sb [4][$];
  string       nm [4] = '{"A.wr", "A.rd", "B.wr", "B.rd"};
  logic [15:0] model [DEPTH];
  int          edge_cnt = 0;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  ram_pipe #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .WR_LATENCY(WL[0]), .RD_LATENCY(RL[0])) dut_a (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
    .wr_ret_ack(a_wack), .wr_ret_address(a_waddr), .wr_ret_err(a_werr),
    .rd_en(rd_en), .rd_address(rd_address),
    .rd_ret_ack(a_rack), .rd_ret_address(a_raddr), .rd_ret_data(a_rdata), .rd_ret_err(a_rerr)
  );

  ram_pipe #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .WR_LATENCY(WL[1]), .RD_LATENCY(RL[1])) dut_b (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
    .wr_ret_ack(b_wack), .wr_ret_address(b_waddr), .wr_ret_err(b_werr),
    .rd_en(rd_en), .rd_address(rd_address),
    .rd_ret_ack(b_rack), .rd_ret_address(b_raddr), .rd_ret_data(b_rdata), .rd_ret_err(b_rerr)
  );

  assign o_ack[0] = a_wack;  assign o_addr[0] = a_waddr; assign o_data[0] = '0;      assign o_err[0] = a_werr;
  assign o_ack[1] = a_rack;  assign o_addr[1] = a_raddr; assign o_data[1] = a_rdata; assign o_err[1] = a_rerr;
  assign o_ack[2] = b_wack;  assign o_addr[2] = b_waddr; assign o_data[2] = '0;      assign o_err[2] = b_werr;
  assign o_ack[3] = b_rack;  assign o_addr[3] = b_raddr; assign o_data[3] = b_rdata; assign o_err[3] = b_rerr;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
  endtask

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  // Monitor: pops on every ack, checks idle fields are zero, flags overdue entries.
  initial forever begin
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (o_ack[k] === 1'b1) begin
        if (sb[k].size() == 0) begin
          n_chk++;
          $display("FAIL %s unexpected ack addr=%h at edge %0d", nm[k], o_addr[k], edge_cnt);
        end else begin
          e = sb[k].pop_front();
          chk({nm[k], " ret"},
              {32'(edge_cnt), o_addr[k], o_data[k], 31'd0, o_err[k]},
              {32'(e.due), e.r.address, e.r.data, 31'd0, e.r.err});
        end
      end else begin
        chk({nm[k], " idle"}, {63'd0, o_ack[k], o_addr[k], o_data[k], o_err[k]}, 96'd0);
        if (sb[k].size() > 0 && sb[k][0].due <= edge_cnt) begin
          e = sb[k].pop_front();
          n_chk++;
          $display("FAIL %s missing ack addr=%h due edge %0d, now %0d", nm[k], e.r.address, e.due, edge_cnt);
        end
      end
    end
  end

  task automatic step(input bit rst, input bit we, input int wa, input int wd, input bit re, input int ra);
    exp_t e;
    @(negedge clk);
    reset = rst; wr_en = we; wr_address = 16'(wa); wr_data = 16'(wd);
    rd_en = re; rd_address = 16'(ra);
    if (!rst) begin
      if (re) begin
        e.r.ack = 1'b1;
        e.r.address = 16'(ra);
        if (ra >= DEPTH) begin
          e.r.data = '0; e.r.err = 1'b1;
        end else begin
          e.r.err = 1'b0;
`ifdef RAM_PIPE_FORWARD_EN
          if (we && wa == ra) e.r.data = 16'(wd);
          else
`endif
          e.r.data = model[ra];
        end
        for (int d = 0; d < 2; d++) begin
          e.due = edge_cnt + RL[d];
          sb[2*d+1].push_back(e);
        end
      end
      if (we) begin
        e.r.ack = 1'b1;
        e.r.address = 16'(wa);
        e.r.data = '0;
        e.r.err = (wa >= DEPTH);
        for (int d = 0; d < 2; d++) begin
          e.due = edge_cnt + WL[d];
          sb[2*d].push_back(e);
        end
      end
    end
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) sb[k].delete();
    end else if (we && wa < DEPTH) begin
      model[wa] = 16'(wd);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    for (int a = 0; a < DEPTH; a++) step(0, 1, a, int'($urandom_range(0, 16'hFFFF)), 0, 0);
    idle(5);

    // write then read back
    step(0, 1, 16'h0096, 16'h0000, 0, 0);
    idle(3);
    step(0, 0, 0, 0, 1, 16'h0096);
    idle(5);

    // streaming: writes 150..159, reads of the same addresses 10 cycles later
    for (int i = 0; i < 20; i++)
      step(0, i < 10, 150 + i, i, i >= 10, 150 + i - 10);
    idle(5);

    // same-edge collision
    step(0, 1, 16'h0010, 16'h00AA, 0, 0);
    idle(1);
    step(0, 1, 16'h0010, 16'h0055, 1, 16'h0010);
    idle(1);
    step(0, 0, 0, 0, 1, 16'h0010);
    idle(5);

    // out of range
    step(0, 1, 300, 16'h1234, 0, 0);
    step(0, 0, 0, 0, 1, 300);
    step(0, 0, 0, 0, 1, 44);
    idle(5);

    // reset mid-flight, with requests held during reset
    step(0, 1, 16'h0020, 16'hBEEF, 0, 0);
    step(0, 0, 0, 0, 1, 16'h0020);
    idle(1);
    step(1, 1, 16'h0021, 16'h7777, 1, 16'h0020);
    idle(5);
    step(0, 0, 0, 0, 1, 16'h0020);
    step(0, 0, 0, 0, 1, 16'h0021);
    idle(5);

    // alternating reads with idle gaps
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, (i % 2) == 0, 40 + i);
    idle(5);

    // randomized traffic with occasional collisions and resets
    for (int i = 0; i < 500; i++) begin
      int wa, ra;
      wa = int'($urandom_range(0, 299));
      ra = ($urandom % 4 == 0) ? wa : int'($urandom_range(0, 299));
      step(($urandom % 60) == 0, $urandom % 2, wa, int'($urandom_range(0, 16'hFFFF)),
           $urandom % 2, ra);
    end
    idle(8);

    for (int k = 0; k < 4; k++)
      chk({nm[k], " drained"}, 96'(sb[k].size()), 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
